// File: rtl/gate_logic_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : gate_logic_unit_if
// Description : Operand/result handshake bundle for gate_logic_unit.
//               master = operand source + result consumer, slave = the unit.
//               Operand side : in_valid/in_ready, op, acc_mode, acc_clr, a, b
//               Result side  : out_valid/out_ready, y, zero, ones, parity,
//                              txn_cnt
// Revision    : 1.0 - initial release
// ============================================================================
interface gate_logic_unit_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic             acc_mode;
    logic             acc_clr;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             zero;
    logic             ones;
    logic             parity;
    logic [CNT_W-1:0] txn_cnt;

    modport master (
        output in_valid, op, acc_mode, acc_clr, a, b, out_ready,
        input  in_ready, out_valid, y, zero, ones, parity, txn_cnt
    );

    modport slave (
        input  in_valid, op, acc_mode, acc_clr, a, b, out_ready,
        output in_ready, out_valid, y, zero, ones, parity, txn_cnt
    );
endinterface
`default_nettype wire

// File: rtl/gate_logic_unit.sv
`default_nettype none
// ============================================================================
// Module      : gate_logic_unit
// Description : Two-stage pipelined bitwise gate unit with valid/ready on
//               both sides, accumulator feedback and a delivery counter.
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - gate_logic_unit_if.slave (operands in, result + flags out)
// Revision    : 1.0 - initial release
// ============================================================================
module gate_logic_unit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    gate_logic_unit_if.slave  bus
);

    localparam logic [2:0] c_OP_AND  = 3'd0;
    localparam logic [2:0] c_OP_OR   = 3'd1;
    localparam logic [2:0] c_OP_XOR  = 3'd2;
    localparam logic [2:0] c_OP_XNOR = 3'd3;
    localparam logic [2:0] c_OP_NAND = 3'd4;
    localparam logic [2:0] c_OP_NOR  = 3'd5;
    localparam logic [2:0] c_OP_NOTB = 3'd6;

    // Stage 1 (captured operands)
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic             accm_q, accm_d;

    // Stage 2 (result + flags)
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             zero_q, zero_d;
    logic             ones_q, ones_d;
    logic             parity_q, parity_d;

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             w_s2_adv;
    logic             w_accept;
    logic             w_deliver;
    logic [WIDTH-1:0] w_opa;
    logic [WIDTH-1:0] w_res;

    assign w_s2_adv  = s1_valid_q && (!out_valid_q || bus.out_ready);
    assign w_accept  = bus.in_valid && bus.in_ready;
    assign w_deliver = out_valid_q && bus.out_ready;

    // Stage 1 frees up in the same cycle it hands over to stage 2, which is
    // what sustains one transfer per cycle.
    assign bus.in_ready = !s1_valid_q || w_s2_adv;

    // Operand A comes from the accumulator, which already reflects the result
    // computed at the previous edge, so chained accumulate ops run at full rate.
    assign w_opa = accm_q ? acc_q : a_q;

    always_comb begin
        w_res = '0;
        case (op_q)
            c_OP_AND:  w_res = w_opa & b_q;
            c_OP_OR:   w_res = w_opa | b_q;
            c_OP_XOR:  w_res = w_opa ^ b_q;
            c_OP_XNOR: w_res = ~(w_opa ^ b_q);
            c_OP_NAND: w_res = ~(w_opa & b_q);
            c_OP_NOR:  w_res = ~(w_opa | b_q);
            c_OP_NOTB: w_res = ~b_q;
            default:   w_res = w_opa;
        endcase
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        accm_d     = accm_q;
        if (w_accept) begin
            s1_valid_d = 1'b1;
            a_d        = bus.a;
            b_d        = bus.b;
            op_d       = bus.op;
            accm_d     = bus.acc_mode;
        end else if (w_s2_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    // Result registers only move on advance, so y/flags hold under backpressure.
    always_comb begin
        out_valid_d = out_valid_q;
        y_d         = y_q;
        zero_d      = zero_q;
        ones_d      = ones_q;
        parity_d    = parity_q;
        if (w_s2_adv) begin
            out_valid_d = 1'b1;
            y_d         = w_res;
            zero_d      = (w_res == '0);
            ones_d      = &w_res;
            parity_d    = ^w_res;
        end else if (w_deliver) begin
            out_valid_d = 1'b0;
        end
    end

    // Clear wins over a simultaneous load; the loaded value still goes to y.
    always_comb begin
        acc_d = acc_q;
        if (bus.acc_clr) begin
            acc_d = '0;
        end else if (w_s2_adv && accm_q) begin
            acc_d = w_res;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (w_deliver) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            accm_q      <= 1'b0;
            out_valid_q <= 1'b0;
            y_q         <= '0;
            zero_q      <= 1'b1;
            ones_q      <= 1'b0;
            parity_q    <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            accm_q      <= accm_d;
            out_valid_q <= out_valid_d;
            y_q         <= y_d;
            zero_q      <= zero_d;
            ones_q      <= ones_d;
            parity_q    <= parity_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.y         = y_q;
    assign bus.zero      = zero_q;
    assign bus.ones      = ones_q;
    assign bus.parity    = parity_q;
    assign bus.txn_cnt   = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_gate_logic_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_gate_logic_unit
// Description : Self-checking bench for gate_logic_unit (WIDTH=8, CNT_W=4).
//               A transaction-level model predicts handshake, result, flags
//               and counter every cycle; directed sequences pin literal values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gate_logic_unit;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic clk;
    logic rst_n;

    gate_logic_unit_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    gate_logic_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Each op is a 4-entry truth table indexed by {a_bit, b_bit}.
    function automatic logic [WIDTH-1:0] gate(input logic [2:0] op,
                                              input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] z);
        logic [3:0]       tt;
        logic [WIDTH-1:0] r;
        case (op)
            3'd0: tt = 4'b1000;
            3'd1: tt = 4'b1110;
            3'd2: tt = 4'b0110;
            3'd3: tt = 4'b1001;
            3'd4: tt = 4'b0111;
            3'd5: tt = 4'b0001;
            3'd6: tt = 4'b0101;
            default: tt = 4'b1100;
        endcase
        for (int i = 0; i < WIDTH; i++) r[i] = tt[{x[i], z[i]}];
        return r;
    endfunction

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [2:0]       op;
        logic             accm;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } txn_t;

    txn_t m_pend[$];          // accepted, not yet computed (at most one)
    logic             m_have_out;
    logic [WIDTH-1:0] m_y;
    logic [WIDTH-1:0] m_acc;
    int               m_cnt;

    function automatic logic m_in_ready();
        return (m_pend.size() == 0) || !m_have_out || bus.out_ready;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend.delete();
            m_have_out = 1'b0;
            m_y        = '0;
            m_acc      = '0;
            m_cnt      = 0;
        end else begin
            logic   take;
            logic   move;
            txn_t   t;
            logic [WIDTH-1:0] r;
            take = bus.in_valid && m_in_ready();
            move = (m_pend.size() != 0) && (!m_have_out || bus.out_ready);
            if (m_have_out && bus.out_ready) begin
                m_cnt      = (m_cnt + 1) % (1 << CNT_W);
                m_have_out = 1'b0;
            end
            if (move) begin
                t = m_pend.pop_front();
                r = gate(t.op, t.accm ? m_acc : t.a, t.b);
                m_y        = r;
                m_have_out = 1'b1;
                if (t.accm) m_acc = r;
            end
            if (bus.acc_clr) m_acc = '0;
            if (take) m_pend.push_back('{bus.op, bus.acc_mode, bus.a, bus.b});
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [WIDTH-1:0] got[$];

    always @(negedge clk) begin
        chk("in_ready",  bus.in_ready,  m_in_ready());
        chk("out_valid", bus.out_valid, m_have_out);
        chk("y",         bus.y,         m_y);
        chk("zero",      bus.zero,      m_y == '0);
        chk("ones",      bus.ones,      $countones(m_y) == WIDTH);
        chk("parity",    bus.parity,    $countones(m_y) % 2);
        chk("txn_cnt",   bus.txn_cnt,   m_cnt);
        if (bus.out_valid && bus.out_ready) got.push_back(bus.y);
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic v, input logic [2:0] op, input logic accm,
                         input logic clr, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b);
        bus.in_valid = v;
        bus.op       = op;
        bus.acc_mode = accm;
        bus.acc_clr  = clr;
        bus.a        = a;
        bus.b        = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 3'd0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic chk_got(input string name, input logic [WIDTH-1:0] exp[$]);
        chk({name, "_count"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            chk(name, got[i], exp[i]);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_in_ready",  bus.in_ready,  1'b1);
        chk("rst_y",         bus.y,         '0);
        chk("rst_zero",      bus.zero,      1'b1);
        chk("rst_txn_cnt",   bus.txn_cnt,   '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, limit 1000000 expected earlier end");
        $fatal(1, "timeout");
    end

    initial begin
        logic [WIDTH-1:0] exp[$];
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.op       = '0;
        bus.acc_mode = 1'b0;
        bus.acc_clr  = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // All eight ops back-to-back.
        got.delete();
        for (int op = 0; op < 8; op++) drive(1'b1, 3'(op), 1'b0, 1'b0, 8'hF0, 8'h3C);
        idle(3);
        exp = '{8'h30, 8'hFC, 8'hCC, 8'h33, 8'hCF, 8'h03, 8'hC3, 8'hF0};
        chk_got("ops", exp);

        // Backpressure: only two transactions absorbed.
        got.delete();
        bus.out_ready = 1'b0;
        drive(1'b1, 3'd0, 1'b0, 1'b0, 8'hFF, 8'h11);
        drive(1'b1, 3'd0, 1'b0, 1'b0, 8'hFF, 8'h22);
        drive(1'b1, 3'd0, 1'b0, 1'b0, 8'hFF, 8'h33);
        drive(1'b1, 3'd0, 1'b0, 1'b0, 8'hFF, 8'h44);
        chk("bp_in_ready", bus.in_ready, 1'b0);
        chk("bp_y_held",   bus.y,        8'h11);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        idle(4);
        exp = '{8'h11, 8'h22};
        chk_got("bp", exp);

        // Accumulate chain, then a non-accumulate op leaves acc alone.
        got.delete();
        idle(0);
        drive(1'b0, 3'd0, 1'b0, 1'b1, 8'h00, 8'h00);
        drive(1'b1, 3'd2, 1'b1, 1'b0, 8'hA5, 8'h01);
        drive(1'b1, 3'd2, 1'b1, 1'b0, 8'hA5, 8'h02);
        drive(1'b1, 3'd2, 1'b1, 1'b0, 8'hA5, 8'h04);
        drive(1'b1, 3'd6, 1'b0, 1'b0, 8'h00, 8'hAA);
        drive(1'b1, 3'd2, 1'b1, 1'b0, 8'h5A, 8'h00);
        idle(3);
        exp = '{8'h01, 8'h03, 8'h07, 8'h55, 8'h07};
        chk_got("acc", exp);

        // Clear coincident with an accumulate load.
        got.delete();
        drive(1'b1, 3'd2, 1'b1, 1'b0, 8'h00, 8'h01);
        drive(1'b0, 3'd0, 1'b0, 1'b1, 8'h00, 8'h00);
        drive(1'b1, 3'd2, 1'b1, 1'b0, 8'hFF, 8'h00);
        idle(3);
        exp = '{8'h06, 8'h00};
        chk_got("clr_load", exp);

        // Randomized traffic with a reset dropped in mid-stream.
        for (int i = 0; i < 600; i++) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0),
                  8'($urandom), 8'($urandom));
            if (i == 300) begin
                #2;
                do_reset();
            end
        end
        bus.out_ready = 1'b1;
        idle(3);

        // Counter wrap with a 4-bit counter.
        do_reset();
        for (int i = 0; i < 17; i++) drive(1'b1, 3'd1, 1'b0, 1'b0, 8'($urandom), 8'h00);
        idle(3);
        chk("cnt_wrap", bus.txn_cnt, 4'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
